sync_counter_ctrl: RTL and testbench

- Sequencing controller for the 4-bit synchronous counter (`sync_counter_4bit` datapath): arms, clears, enables, pauses and terminates counting runs against a programmable terminal count.
- Supports one-shot and periodic (auto-rearm) modes.
- Drives the counter's clear/enable inputs and observes its q output.
- Reports completion with a one-cycle done pulse.

---
 rtl/sync_counter_ctrl.sv | 102 ++++++++++
 tb/tb_sync_counter_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_counter_ctrl.sv
// rtl/sync_counter_ctrl.sv - sequencing controller for a 4-bit synchronous counter
module sync_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             periodic,
    input  logic [WIDTH-1:0] term,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] term_r
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t state;
    logic   mode_periodic;
    logic   terminal;

    // Out-of-range counter values also terminate, hence >= rather than ==.
    assign terminal = (cnt_q >= term_r);

    // Enable is the one output that follows cnt_q directly, so the counter
    // stops exactly on the terminal value and never wraps.
    assign cnt_en = (state == RUN) && !terminal;

    // State register with cnt_clr/busy/done registered alongside the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt_clr       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            term_r        <= '0;
            mode_periodic <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        term_r        <= term;
                        mode_periodic <= periodic;
                        state         <= ARM;
                        cnt_clr       <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                ARM: begin
                    cnt_clr <= 1'b0;
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (terminal) begin
                        done <= 1'b1;
                        if (mode_periodic) begin
                            state   <= ARM;
                            cnt_clr <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (hold) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!hold) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt_clr <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_counter_ctrl.sv
// tb/tb_sync_counter_ctrl.sv - scoreboard bench for sync_counter_ctrl with counter model
module tb_sync_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       hold = 1'b0;
    logic       periodic = 1'b0;
    logic [3:0] term = 4'd0;
    logic [3:0] cnt_q = 4'd0;
    logic       cnt_clr;
    logic       cnt_en;
    logic       busy;
    logic       done;
    logic [3:0] term_r;

    int total = 0;
    int bad = 0;

    logic [11:0] exp_q[$];

    // Reference model state: a run is active, a clear is pending this cycle,
    // or the run is paused; otherwise an active run is counting.
    bit       m_active = 0;
    bit       m_clear = 0;
    bit       m_paused = 0;
    bit       m_per = 0;
    bit       m_done = 0;
    int       m_term = 0;
    int       m_q = 0;

    always #5 clk = ~clk;

    sync_counter_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .periodic (periodic),
        .term     (term),
        .cnt_q    (cnt_q),
        .cnt_clr  (cnt_clr),
        .cnt_en   (cnt_en),
        .busy     (busy),
        .done     (done),
        .term_r   (term_r)
    );

    // The counter datapath the controller drives.
    always @(posedge clk) begin
        if (cnt_clr)
            cnt_q <= 4'd0;
        else if (cnt_en)
            cnt_q <= cnt_q + 4'd1;
    end

    // Drive one cycle of inputs, record the expected outputs of this cycle,
    // then advance the model to the next cycle.
    task automatic step(input bit r, input bit s, input bit sp, input bit h,
                        input bit p, input int t);
        bit counting;
        bit e_en;
        int n_q;
        rst = r;
        start = s;
        stop = sp;
        hold = h;
        periodic = p;
        term = t[3:0];
        counting = m_active && !m_clear && !m_paused;
        e_en = counting && (m_q < m_term);
        exp_q.push_back({m_active, m_clear, e_en, m_done, m_term[3:0], m_q[3:0]});
        if (m_clear)
            n_q = 0;
        else if (e_en)
            n_q = (m_q + 1) % 16;
        else
            n_q = m_q;
        m_done = 0;
        if (r) begin
            m_active = 0;
            m_clear = 0;
            m_paused = 0;
            m_per = 0;
            m_term = 0;
        end else if (!m_active) begin
            if (s && !sp) begin
                m_active = 1;
                m_clear = 1;
                m_term = t;
                m_per = p;
            end
        end else if (sp) begin
            m_active = 0;
            m_clear = 0;
            m_paused = 0;
        end else if (m_clear) begin
            m_clear = 0;
        end else if (m_paused) begin
            if (!h)
                m_paused = 0;
        end else if (m_q >= m_term) begin
            m_done = 1;
            if (m_per)
                m_clear = 1;
            else
                m_active = 0;
        end else if (h) begin
            m_paused = 1;
        end
        m_q = n_q;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic go(input int t, input bit p);
        step(0, 1, 0, 0, p, t);
    endtask

    // Monitor: every cycle the DUT presents outputs, check them against the
    // oldest expected entry.
    always @(negedge clk) begin
        logic [11:0] exp_v;
        logic [11:0] got_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {busy, cnt_clr, cnt_en, done, term_r, cnt_q};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL outputs t=%0t got busy/clr/en/done=%b%b%b%b term_r=%0d q=%0d required busy/clr/en/done=%b%b%b%b term_r=%0d q=%0d",
                         $time, got_v[11], got_v[10], got_v[9], got_v[8], got_v[7:4], got_v[3:0],
                         exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:4], exp_v[3:0]);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(2);

        go(5, 0);
        idle(10);

        go(3, 1);
        idle(18);
        step(0, 0, 1, 0, 0, 0);
        idle(2);

        go(10, 0);
        idle(5);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 1, 0, 0);
        idle(14);

        go(12, 0);
        idle(7);
        step(0, 0, 1, 0, 0, 0);
        idle(3);
        go(2, 0);
        idle(6);

        go(0, 0);
        idle(4);
        go(0, 1);
        idle(6);
        step(0, 0, 1, 0, 0, 0);
        idle(2);
        go(15, 0);
        idle(20);

        step(0, 1, 1, 0, 0, 7);
        idle(2);

        go(8, 0);
        idle(3);
        step(0, 1, 0, 0, 1, 2);
        idle(9);

        go(9, 0);
        idle(3);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit s;
            bit sp;
            bit h;
            bit p;
            int t;
            r  = ($urandom_range(0, 63) == 0);
            sp = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 4) == 0);
            p  = $urandom_range(0, 1);
            t  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 15);
            step(r, s, sp, h, p, t);
        end
        idle(3);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
